// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: sequencing wrapper around an external combinational
// unsigned divider. It captures the operands, drives their magnitudes to the
// divider, waits SETTLE_CYCLES for the divider to settle, and then writes
// sign-corrected HI (remainder) and LO (quotient) values.
// A zero divisor skips the settle wait and produces the fixed div-by-zero
// result.
module div_hilo_ctrl #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sq_q, sq_d;         // quotient needs negation
    logic             sr_q, sr_d;         // remainder needs negation
    logic             zero_q, zero_d;     // divisor was zero at accept
    logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
    logic [WIDTH-1:0] mag_dvd_q, mag_dvd_d;
    logic [WIDTH-1:0] mag_dvs_q, mag_dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    // Operand sign decode. Unsigned mode never negates.
    logic             neg_dvd, neg_dvs;
    assign neg_dvd = signed_op & dividend[WIDTH-1];
    assign neg_dvs = signed_op & divisor[WIDTH-1];

    // Next-state and datapath-update logic; every register holds by default.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sq_d      = sq_q;
        sr_d      = sr_q;
        zero_d    = zero_q;
        dvd_raw_d = dvd_raw_q;
        mag_dvd_d = mag_dvd_q;
        mag_dvs_d = mag_dvs_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sq_d      = neg_dvd ^ neg_dvs;
                    sr_d      = neg_dvd;
                    zero_d    = (divisor == '0);
                    dvd_raw_d = dividend;
                    mag_dvd_d = neg_dvd ? -dividend : dividend;
                    mag_dvs_d = neg_dvs ? -divisor : divisor;
                    dbz_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = (divisor == '0) ? S_WRITE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (zero_q) begin
                    lo_d  = '1;
                    hi_d  = dvd_raw_q;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = sq_q ? -div_quotient : div_quotient;
                    hi_d = sr_q ? -div_remainder : div_remainder;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; clear abandons any operation in flight.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sq_q      <= 1'b0;
            sr_q      <= 1'b0;
            zero_q    <= 1'b0;
            dvd_raw_q <= '0;
            mag_dvd_q <= '0;
            mag_dvs_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sq_q      <= sq_d;
            sr_q      <= sr_d;
            zero_q    <= zero_d;
            dvd_raw_q <= dvd_raw_d;
            mag_dvd_q <= mag_dvd_d;
            mag_dvs_q <= mag_dvs_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy         = (state_q == S_SETTLE) || (state_q == S_WRITE);
    assign done         = (state_q == S_DONE);
    assign div_dividend = mag_dvd_q;
    assign div_divisor  = mag_dvs_q;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;
    assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Testbench for div_hilo_ctrl: models the external divider, issues directed
// and random divide requests, and scoreboards every done pulse against a
// reference computed with 64-bit signed arithmetic.
module tb_div_hilo_ctrl;

    localparam int W   = 32;
    localparam int LAT = 3;   // SETTLE_CYCLES + 1

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic          signed_op;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic [W-1:0]  div_dividend;
    logic [W-1:0]  div_divisor;
    logic [W-1:0]  div_quotient;
    logic [W-1:0]  div_remainder;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [W-1:0]  hi_out;
    logic [W-1:0]  lo_out;

    always #5 clock = ~clock;

    div_hilo_ctrl #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
        .clock         (clock),
        .clear         (clear),
        .start         (start),
        .signed_op     (signed_op),
        .dividend      (dividend),
        .divisor       (divisor),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .busy          (busy),
        .done          (done),
        .div_by_zero   (div_by_zero),
        .hi_out        (hi_out),
        .lo_out        (lo_out)
    );

    // Combinational unsigned divider the controller wraps.
    assign div_quotient  = (div_divisor == '0) ? '1 : div_dividend / div_divisor;
    assign div_remainder = (div_divisor == '0) ? div_dividend : div_dividend % div_divisor;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        logic [W-1:0] mag_a;
        logic [W-1:0] mag_b;
        int           acc;   // posedge number of the accept edge
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference: integer division truncating toward zero; remainder follows dividend.
    function automatic exp_t model(input logic s, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int acc);
        exp_t   e;
        longint sa, sb, qq, rr;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        e.mag_a = (sa < 0) ? W'(-sa) : W'(sa);
        e.mag_b = (sb < 0) ? W'(-sb) : W'(sb);
        e.acc   = acc;
        if (b == '0) begin
            e.lo  = '1;
            e.hi  = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            qq    = sa / sb;
            rr    = sa % sb;
            e.lo  = qq[W-1:0];
            e.hi  = rr[W-1:0];
            e.dbz = 1'b0;
            e.lat = LAT;
        end
        return e;
    endfunction

    // Monitor: checks reset outputs, busy window, operands, and each done pulse.
    always @(negedge clock) begin
        exp_t e;
        int   d;
        if (!clear) begin
            total = total + 3;
            if (busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL rst_ctrl busy=%b done=%b want 0 0", busy, done);
            end
            if (div_by_zero !== 1'b0 || hi_out !== '0 || lo_out !== '0) begin
                bad++;
                $display("FAIL rst_res dbz=%b hi=%h lo=%h want 0", div_by_zero, hi_out, lo_out);
            end
            if (div_dividend !== '0 || div_divisor !== '0) begin
                bad++;
                $display("FAIL rst_opnd dvd=%h dvs=%h want 0", div_dividend, div_divisor);
            end
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) begin
                d = cyc - exp_q[0].acc;
                if (d >= 0 && d < exp_q[0].lat) begin
                    total++;
                    if (busy !== 1'b1 || done !== 1'b0) begin
                        bad++;
                        $display("FAIL busy_win t+%0d busy=%b done=%b want 1 0", d, busy, done);
                    end
                end
                if (d == 0) begin
                    total++;
                    if (div_dividend !== exp_q[0].mag_a || div_divisor !== exp_q[0].mag_b) begin
                        bad++;
                        $display("FAIL magnitudes got %h %h want %h %h", div_dividend,
                                 div_divisor, exp_q[0].mag_a, exp_q[0].mag_b);
                    end
                end
            end
            if (done === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc - e.acc != e.lat) begin
                        bad++;
                        $display("FAIL latency got %0d want %0d", cyc - e.acc, e.lat);
                    end
                    total = total + 3;
                    if (lo_out !== e.lo) begin
                        bad++;
                        $display("FAIL lo_out got %h want %h", lo_out, e.lo);
                    end
                    if (hi_out !== e.hi) begin
                        bad++;
                        $display("FAIL hi_out got %h want %h", hi_out, e.hi);
                    end
                    if (div_by_zero !== e.dbz || busy !== 1'b0) begin
                        bad++;
                        $display("FAIL dbz_busy got %b %b want %b 0", div_by_zero, busy, e.dbz);
                    end
                    $display("op acc=%0d lo=%h hi=%h dbz=%b", e.acc, lo_out, hi_out, div_by_zero);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while ((busy || done) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            $display("FAIL wait_idle timeout at cycle %0d", cyc);
            $fatal(1, "controller stuck busy");
        end
    endtask

    // Issue one request; optionally pulse start again while the op is in flight.
    task automatic do_op(input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit extra_start);
        wait_idle();
        start     = 1'b1;
        signed_op = s;
        dividend  = a;
        divisor   = b;
        exp_q.push_back(model(s, a, b, cyc + 1));
        @(negedge clock);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        if (extra_start) begin
            start     = 1'b1;
            signed_op = ~s;
            @(negedge clock);
            start = 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        int n;
        clear     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clock);
        #1 clear = 1'b1;

        do_op(1'b0, 32'd100, 32'd7, 1'b0);
        do_op(1'b1, -32'sd100, 32'd7, 1'b0);
        do_op(1'b1, 32'd100, -32'sd7, 1'b0);
        do_op(1'b1, -32'sd100, -32'sd7, 1'b0);
        do_op(1'b0, 32'h12345678, 32'd0, 1'b0);
        do_op(1'b0, 32'd9, 32'd3, 1'b0);
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        do_op(1'b0, 32'hFFFFFFFF, 32'd2, 1'b0);
        do_op(1'b0, 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b0);
        do_op(1'b0, 32'd1000, 32'd10, 1'b1);

        // Reset in the middle of SETTLE: the op must vanish without a done.
        wait_idle();
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 32'd77;
        divisor   = 32'd3;
        exp_q.push_back(model(1'b0, 32'd77, 32'd3, cyc + 1));
        @(negedge clock);
        start = 1'b0;
        #1 clear = 1'b0;
        repeat (3) @(negedge clock);
        #1 clear = 1'b1;
        do_op(1'b0, 32'd50, 32'd5, 1'b0);

        for (int i = 0; i < 120; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: b = -W'($urandom_range(1, 15));
                3: b = $urandom;
                4: b = '1;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_op(1'($urandom_range(0, 1)), a, b, ($urandom_range(0, 4) == 0));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (5) @(negedge clock);
        if (exp_q.size() != 0) begin
            $display("FAIL drain %0d ops never completed", exp_q.size());
            $fatal(1, "missing done");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
